// File: rtl/squeeze_scheduler_if.sv
// squeeze_scheduler_if
//   Groups the control/handshake signals of the SHAKE squeeze scheduler.
//   master : the scheduler side (drives hand-off, permutation request, status)
//   slave  : the environment side (start request, dump-stage and Keccak-core
//            feedback)
//
// Handshake semantics (all signals sampled on the rising clock edge):
//   - start is a one-cycle request, honoured only while the scheduler is idle;
//     out_len is captured in the same cycle.
//   - output_buffer_we_out is a one-cycle pulse that hands over the current
//     state block. It is only issued after output_buffer_available_wr was seen
//     high. The dump stage must drop available within three cycles of a
//     hand-off, so one available level never produces two writes.
//   - perm_start is a one-cycle request. perm_done is a one-cycle pulse from the
//     core and is only listened to while a permutation is outstanding.
//   - last_output_block_out and last_block_bytes qualify output_buffer_we_out.
//
// Ports:
//   start, out_len, output_buffer_available_wr, perm_done      -> scheduler
//   output_buffer_we_out, last_output_block_out, last_block_bytes,
//   perm_start, busy, done, block_count, state_dbg             <- scheduler
interface squeeze_scheduler_if #(
  parameter int LEN_W = 32
);
  logic             start;
  logic [LEN_W-1:0] out_len;
  logic             output_buffer_available_wr;
  logic             perm_done;
  logic             output_buffer_we_out;
  logic             last_output_block_out;
  logic [7:0]       last_block_bytes;
  logic             perm_start;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] block_count;
  logic [2:0]       state_dbg;

  modport master (
    input  start,
    input  out_len,
    input  output_buffer_available_wr,
    input  perm_done,
    output output_buffer_we_out,
    output last_output_block_out,
    output last_block_bytes,
    output perm_start,
    output busy,
    output done,
    output block_count,
    output state_dbg
  );

  modport slave (
    output start,
    output out_len,
    output output_buffer_available_wr,
    output perm_done,
    input  output_buffer_we_out,
    input  last_output_block_out,
    input  last_block_bytes,
    input  perm_start,
    input  busy,
    input  done,
    input  block_count,
    input  state_dbg
  );
endinterface

// File: rtl/squeeze_scheduler.sv
// squeeze_scheduler
//   Sequences the SHAKE squeeze phase: hands rate-sized state blocks to the
//   dump stage, requests a Keccak permutation between blocks, and flags the
//   final block together with its count of valid bytes.
//
// Parameters:
//   RATE_BYTES : squeeze rate in bytes (1..255)
//   LEN_W      : width of the requested output length
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : squeeze_scheduler_if.master (see interface for signal semantics);
//         bus.state_dbg exposes the current FSM state.
//
// All outputs are flops loaded from the next state, so each output is a pure
// function of the state being entered and no input reaches an output
// combinationally.
module squeeze_scheduler #(
  parameter int RATE_BYTES = 136,
  parameter int LEN_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  squeeze_scheduler_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_AVAIL = 3'd1,
    S_ISSUE      = 3'd2,
    S_PERMUTE    = 3'd3,
    S_WAIT_PERM  = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  localparam logic [LEN_W-1:0] RATE_L = LEN_W'(RATE_BYTES);

  state_t           state_q;
  state_t           state_d;
  logic [LEN_W-1:0] remaining_q;
  logic [LEN_W-1:0] block_count_q;
  logic             we_q;
  logic             last_q;
  logic [7:0]       bytes_q;
  logic             perm_start_q;
  logic             busy_q;
  logic             done_q;
  logic             final_block;

  // remaining only changes when leaving ISSUE, so it is already stable in
  // WAIT_AVAIL and can qualify the registered last/bytes outputs loaded on
  // the edge into ISSUE. An exact multiple of the rate therefore ends with
  // remaining == RATE_BYTES, never 0.
  assign final_block = (remaining_q <= RATE_L);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = (bus.out_len == '0) ? S_DONE : S_WAIT_AVAIL;
        end
      end
      S_WAIT_AVAIL: begin
        if (bus.output_buffer_available_wr) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = final_block ? S_DONE : S_PERMUTE;
      end
      S_PERMUTE: begin
        state_d = S_WAIT_PERM;
      end
      S_WAIT_PERM: begin
        if (bus.perm_done) state_d = S_WAIT_AVAIL;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      remaining_q   <= '0;
      block_count_q <= '0;
      we_q          <= 1'b0;
      last_q        <= 1'b0;
      bytes_q       <= 8'd0;
      perm_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == S_IDLE && bus.start) begin
        remaining_q   <= bus.out_len;
        block_count_q <= '0;
      end

      if (state_q == S_ISSUE) begin
        block_count_q <= block_count_q + LEN_W'(1);
        if (!final_block) remaining_q <= remaining_q - RATE_L;
      end

      we_q         <= (state_d == S_ISSUE);
      last_q       <= (state_d == S_ISSUE) && final_block;
      // RATE_BYTES <= 255, so a final remaining value always fits in 8 bits.
      bytes_q      <= ((state_d == S_ISSUE) && final_block) ? remaining_q[7:0] : 8'd0;
      perm_start_q <= (state_d == S_PERMUTE);
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign bus.output_buffer_we_out  = we_q;
  assign bus.last_output_block_out = last_q;
  assign bus.last_block_bytes      = bytes_q;
  assign bus.perm_start            = perm_start_q;
  assign bus.busy                  = busy_q;
  assign bus.done                  = done_q;
  assign bus.block_count           = block_count_q;
  assign bus.state_dbg             = state_q;

endmodule

// File: tb/tb_squeeze_scheduler.sv
module tb_squeeze_scheduler;
  localparam int R  = 136;
  localparam int LW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  squeeze_scheduler_if #(.LEN_W(LW)) bus();
  squeeze_scheduler #(.RATE_BYTES(R), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];   // {last, bytes} per expected hand-off
  logic [8:0] obs_q[$];   // {last, bytes} per observed hand-off
  int obs_cyc[$];         // cycle of each hand-off, start cycle = 0
  int obs_gap[$];         // cycles from most recent perm_done to hand-off
  int perm_cnt, done_cnt, done_cycle, busy_bad, last_pd;
  logic [LW-1:0] bc_at_done;

  // Reference model: block list from plain arithmetic on the length.
  task automatic model_expected(input int len, output int n);
    exp_q.delete();
    n = (len + R - 1) / R;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) exp_q.push_back({1'b1, 8'(len - (n - 1) * R)});
      else            exp_q.push_back({1'b0, 8'd0});
    end
  endtask

  // ---------------- driver / observer ----------------
  // Cycle c is sampled at the negedge inside it; inputs for the edge ending
  // cycle c are driven right after sampling. start is driven in cycle 0.
  task automatic run_squeeze(input int len, input int perm_lat, input bit rand_drop,
                             input int low_hold);
    int pd_at, hold, post;
    logic busy_exp;
    obs_q.delete(); obs_cyc.delete(); obs_gap.delete();
    perm_cnt = 0; done_cnt = 0; done_cycle = -1; busy_bad = 0; last_pd = -1;
    bc_at_done = '0;
    pd_at = -1; hold = low_hold; post = -1;
    bus.out_len = LW'(len);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (bus.output_buffer_we_out) begin
        obs_q.push_back({bus.last_output_block_out, bus.last_block_bytes});
        obs_cyc.push_back(c);
        obs_gap.push_back(last_pd < 0 ? -1 : c - last_pd);
        if (rand_drop) hold = $urandom_range(1, 10);
      end
      if (bus.perm_start) begin
        perm_cnt++;
        pd_at = c + ((perm_lat > 0) ? perm_lat : int'($urandom_range(1, 30)));
      end
      if (bus.done) begin
        done_cnt++;
        done_cycle = c;
        bc_at_done = bus.block_count;
        post = 3;
      end
      busy_exp = (c > 0) && (done_cycle < 0 || c == done_cycle);
      if (bus.busy !== busy_exp) busy_bad++;
      bus.start     = (c == 0);
      bus.perm_done = (c == pd_at);
      if (c == pd_at) last_pd = c;
      if (hold > 0) begin
        bus.output_buffer_available_wr = 1'b0;
        hold--;
      end else begin
        bus.output_buffer_available_wr = 1'b1;
      end
      if (post == 0) break;
      if (post > 0) post--;
    end
    bus.start = 1'b0;
    bus.perm_done = 1'b0;
    if (done_cycle < 0) $display("FAIL run_timeout: len=%0d got no done, want done", len);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0; bus.out_len = '0;
    bus.output_buffer_available_wr = 1'b0; bus.perm_done = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.output_buffer_we_out, bus.last_output_block_out, bus.last_block_bytes,
         bus.perm_start, bus.busy, bus.done, bus.block_count} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got we=%b last=%b bytes=%0d perm=%b busy=%b done=%b bc=%0d, want all 0",
               bus.output_buffer_we_out, bus.last_output_block_out, bus.last_block_bytes,
               bus.perm_start, bus.busy, bus.done, bus.block_count);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_single_block();
    run_squeeze(32, 24, 1'b0, 0);
    n_cmp++;
    if (obs_q.size() !== 1) begin n_err++; $display("FAIL single_we_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_cmp++;
      if (obs_q[0] !== {1'b1, 8'd32}) begin n_err++; $display("FAIL single_last_bytes: got %h want %h", obs_q[0], {1'b1, 8'd32}); end
      n_cmp++;
      if (obs_cyc[0] !== 2) begin n_err++; $display("FAIL single_we_cycle: got %0d want 2", obs_cyc[0]); end
    end
    n_cmp++;
    if (perm_cnt !== 0) begin n_err++; $display("FAIL single_perm_count: got %0d want 0", perm_cnt); end
    n_cmp++;
    if (done_cycle !== 3) begin n_err++; $display("FAIL single_done_cycle: got %0d want 3", done_cycle); end
    n_cmp++;
    if (bc_at_done !== LW'(1)) begin n_err++; $display("FAIL single_block_count: got %0d want 1", bc_at_done); end
    n_cmp++;
    if (busy_bad !== 0) begin n_err++; $display("FAIL single_busy: got %0d bad cycles want 0", busy_bad); end
  endtask

  task automatic test_exact_rate();
    run_squeeze(R, 24, 1'b0, 0);
    n_cmp++;
    if (obs_q.size() !== 1) begin n_err++; $display("FAIL rate_we_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_cmp++;
      if (obs_q[0] !== {1'b1, 8'(R)}) begin n_err++; $display("FAIL rate_last_bytes: got %h want %h", obs_q[0], {1'b1, 8'(R)}); end
    end
    n_cmp++;
    if (perm_cnt !== 0) begin n_err++; $display("FAIL rate_perm_count: got %0d want 0", perm_cnt); end
  endtask

  task automatic test_multi_block(input int len, input string tag);
    int n;
    model_expected(len, n);
    run_squeeze(len, 24, 1'b0, 0);
    n_cmp++;
    if (obs_q.size() !== n) begin n_err++; $display("FAIL %s_we_count: got %0d want %0d", tag, obs_q.size(), n); end
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL %s_block%0d: got %h want %h", tag, i, obs_q[i], exp_q[i]); end
      if (i > 0) begin
        n_cmp++;
        if (obs_gap[i] !== 2) begin n_err++; $display("FAIL %s_pd_to_we%0d: got %0d want 2", tag, i, obs_gap[i]); end
      end
    end
    n_cmp++;
    if (perm_cnt !== n - 1) begin n_err++; $display("FAIL %s_perm_count: got %0d want %0d", tag, perm_cnt, n - 1); end
    n_cmp++;
    if (bc_at_done !== LW'(n)) begin n_err++; $display("FAIL %s_block_count: got %0d want %0d", tag, bc_at_done, n); end
    n_cmp++;
    if (done_cnt !== 1 || (obs_cyc.size() > 0 && done_cycle !== obs_cyc[obs_cyc.size()-1] + 1)) begin
      n_err++; $display("FAIL %s_done: got count=%0d cycle=%0d want one done right after last hand-off", tag, done_cnt, done_cycle);
    end
  endtask

  task automatic test_zero_len();
    run_squeeze(0, 24, 1'b0, 0);
    n_cmp++;
    if (done_cycle !== 1) begin n_err++; $display("FAIL zero_done_cycle: got %0d want 1", done_cycle); end
    n_cmp++;
    if (obs_q.size() !== 0 || perm_cnt !== 0) begin
      n_err++; $display("FAIL zero_activity: got we=%0d perm=%0d want 0 0", obs_q.size(), perm_cnt);
    end
    n_cmp++;
    if (bc_at_done !== '0) begin n_err++; $display("FAIL zero_block_count: got %0d want 0", bc_at_done); end
  endtask

  task automatic test_avail_stall();
    // available low for cycles 0..10 (ten of them in WAIT_AVAIL), high from 11
    run_squeeze(32, 24, 1'b0, 11);
    n_cmp++;
    if (obs_q.size() !== 1) begin n_err++; $display("FAIL stall_we_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_cmp++;
      if (obs_cyc[0] !== 12) begin n_err++; $display("FAIL stall_we_cycle: got %0d want 12", obs_cyc[0]); end
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    // Abort during a hand-off pulse: we must drop without a clock edge.
    @(negedge clk);
    bus.out_len = LW'(32); bus.start = 1'b1; bus.output_buffer_available_wr = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.output_buffer_we_out !== 1'b1) begin n_err++; $display("FAIL abort_pre_we: got %b want 1", bus.output_buffer_we_out); end
    #2 rst = 1'b0; #1;
    n_cmp++;
    if ({bus.output_buffer_we_out, bus.last_output_block_out, bus.last_block_bytes,
         bus.busy, bus.block_count} !== '0) begin
      n_err++; $display("FAIL abort_we_drop: got we=%b last=%b busy=%b want 0 0 0",
                        bus.output_buffer_we_out, bus.last_output_block_out, bus.busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // Abort in WAIT_PERM of a 300-byte run.
    @(negedge clk);
    bus.out_len = LW'(300); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (bus.perm_start) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b1) begin n_err++; $display("FAIL abort_perm_seen: got 0 want 1"); end
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.perm_start, bus.output_buffer_we_out} !== 3'b100) begin
      n_err++; $display("FAIL abort_wait_perm: got busy/perm/we=%b want 100", {bus.busy, bus.perm_start, bus.output_buffer_we_out});
    end
    #2 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if ({bus.output_buffer_we_out, bus.last_output_block_out, bus.last_block_bytes,
           bus.perm_start, bus.busy, bus.done, bus.block_count} !== '0) begin
        n_err++; $display("FAIL abort_outputs%0d: got busy=%b perm=%b done=%b bc=%0d want all 0",
                          c, bus.busy, bus.perm_start, bus.done, bus.block_count);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    run_squeeze(32, 24, 1'b0, 0);
    n_cmp++;
    if (obs_q.size() !== 1 || (obs_q.size() > 0 && (obs_q[0] !== {1'b1, 8'd32} || obs_cyc[0] !== 2))) begin
      n_err++; $display("FAIL abort_rerun_we: got count=%0d want one last block of 32 at cycle 2", obs_q.size());
    end
    n_cmp++;
    if (done_cycle !== 3 || perm_cnt !== 0 || bc_at_done !== LW'(1)) begin
      n_err++; $display("FAIL abort_rerun_done: got done=%0d perm=%0d bc=%0d want 3 0 1", done_cycle, perm_cnt, bc_at_done);
    end
  endtask

  task automatic test_random();
    int len, n, lat, low, first_exp;
    bit drop;
    for (int it = 0; it < 25; it++) begin
      len  = (it % 5 == 4) ? R * int'($urandom_range(1, 6)) : int'($urandom_range(0, 1200));
      lat  = (it % 2 == 0) ? 0 : int'($urandom_range(1, 30));
      drop = 1'($urandom_range(0, 1));
      low  = $urandom_range(0, 6);
      model_expected(len, n);
      run_squeeze(len, lat, drop, low);
      n_cmp++;
      if (done_cnt !== 1) begin n_err++; $display("FAIL rnd%0d_done_count: len=%0d got %0d want 1", it, len, done_cnt); end
      n_cmp++;
      if (obs_q.size() !== n) begin n_err++; $display("FAIL rnd%0d_we_count: len=%0d got %0d want %0d", it, len, obs_q.size(), n); end
      for (int i = 0; i < n && i < obs_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd%0d_block%0d: len=%0d got %h want %h", it, i, len, obs_q[i], exp_q[i]); end
        if (i > 0 && !drop) begin
          n_cmp++;
          if (obs_gap[i] !== 2) begin n_err++; $display("FAIL rnd%0d_pd_to_we%0d: got %0d want 2", it, i, obs_gap[i]); end
        end
      end
      n_cmp++;
      if (perm_cnt !== ((n > 0) ? n - 1 : 0)) begin n_err++; $display("FAIL rnd%0d_perm_count: got %0d want %0d", it, perm_cnt, (n > 0) ? n - 1 : 0); end
      n_cmp++;
      if (bc_at_done !== LW'(n)) begin n_err++; $display("FAIL rnd%0d_block_count: got %0d want %0d", it, bc_at_done, n); end
      n_cmp++;
      if (busy_bad !== 0) begin n_err++; $display("FAIL rnd%0d_busy: got %0d bad cycles want 0", it, busy_bad); end
      if (n > 0 && obs_cyc.size() > 0) begin
        first_exp = (low + 1 > 2) ? low + 1 : 2;
        n_cmp++;
        if (obs_cyc[0] !== first_exp) begin n_err++; $display("FAIL rnd%0d_first_we: got %0d want %0d", it, obs_cyc[0], first_exp); end
        n_cmp++;
        if (done_cycle !== obs_cyc[obs_cyc.size()-1] + 1) begin n_err++; $display("FAIL rnd%0d_done_cycle: got %0d want %0d", it, done_cycle, obs_cyc[obs_cyc.size()-1] + 1); end
      end else if (n == 0) begin
        n_cmp++;
        if (done_cycle !== 1) begin n_err++; $display("FAIL rnd%0d_zero_done: got %0d want 1", it, done_cycle); end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_block();
    test_exact_rate();
    test_multi_block(300, "multi300");
    test_multi_block(2 * R, "multiple272");
    test_zero_len();
    test_avail_stall();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/squeeze_scheduler.md
Name: squeeze_scheduler

Overview:
Sequences the SHAKE squeeze phase once absorption has finished and the Keccak state holds the first output block. It tracks the requested output length and hands each rate-sized block to the dump stage through the output-buffer write/available handshake. Between blocks it requests a permutation from the Keccak core. On the final block it flags the hand-off as last and reports how many bytes of that block are valid.

Parameters:
RATE_BYTES, 136, squeeze rate in bytes (168 for SHAKE128, 136 for SHAKE256); legal range 1..255.
LEN_W, 32, width of the requested output length in bytes.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request to begin squeezing; sampled in IDLE only.
out_len  input  LEN_W  total output bytes requested; captured when start is accepted.
output_buffer_available_wr  input  1  dump stage can accept a new block.
perm_done  input  1  Keccak core finished a permutation; single-cycle pulse.
output_buffer_we_out  output  1  one-cycle pulse that hands the current state block to the dump stage.
last_output_block_out  output  1  qualifies output_buffer_we_out; this block is the final one.
last_block_bytes  output  8  valid bytes in the final block; meaningful while last_output_block_out=1.
perm_start  output  1  one-cycle permutation request to the Keccak core.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse when the squeeze completes.
block_count  output  LEN_W  number of blocks handed off since start was accepted.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs=0; remaining=0; block_count=0.
- All outputs are registered and are a function of the state (Moore); no input reaches an output combinationally.
- States and transitions:
  - IDLE: on start=1, capture remaining=out_len and clear block_count. Go to DONE if out_len=0, else to WAIT_AVAIL. start is ignored in every other state.
  - WAIT_AVAIL: stay while output_buffer_available_wr=0. When it is 1, go to ISSUE.
  - ISSUE: output_buffer_we_out=1 for exactly this cycle; block_count increments.
    - If remaining <= RATE_BYTES: last_output_block_out=1 and last_block_bytes=remaining[7:0]; next state DONE.
    - Else: last_output_block_out=0 and last_block_bytes=0; remaining -= RATE_BYTES; next state PERMUTE.
  - PERMUTE: perm_start=1 for one cycle; go to WAIT_PERM.
  - WAIT_PERM: stay until perm_done=1, then go to WAIT_AVAIL. perm_done is ignored outside WAIT_PERM.
  - DONE: done=1 for one cycle; go to IDLE. busy is still high in DONE.
- Latency:
  - start to first output_buffer_we_out is 2 cycles when available is already high.
  - perm_done to the next output_buffer_we_out is 2 cycles when available is high.
  - Final ISSUE to done is 1 cycle.
- Overlap: a permutation may run while the dump stage drains the previous block; the block is copied at hand-off.
- The earliest re-entry to WAIT_AVAIL is 3 cycles after ISSUE. This guarantees available has dropped after a hand-off, so the same available level never triggers two writes.
- Length arithmetic:
  - The remaining comparison and subtraction are done at LEN_W bits.
  - An exact multiple of RATE_BYTES ends with last_block_bytes=RATE_BYTES, never 0.
  - No extra permutation is issued after the last block.
- Simultaneous events:
  - perm_done together with available=1 in WAIT_PERM: go to WAIT_AVAIL; ISSUE follows next cycle.
  - Reset asserted in any state aborts immediately. perm_start and output_buffer_we_out drop asynchronously, and no done is produced.

Test Plan:
1. RATE=136, start with out_len=32, available=1 -> one we pulse at cycle 2 with last=1 and bytes=32; perm_start never asserted; done at cycle 3; block_count=1.
2. out_len=136 -> single block with last=1, bytes=136; no perm_start.
3. out_len=300, perm_done returned 24 cycles after each perm_start -> 3 we pulses (last=0, 0, 1), final bytes=28, exactly 2 perm_start pulses, block_count=3, then done.
4. out_len=0 -> done at cycle 1; no we pulse; no perm_start; block_count=0.
5. Hold available=0 for 10 cycles in WAIT_AVAIL, then raise it -> no we pulse while low; exactly one we pulse 1 cycle after the rise.
6. Assert rst mid WAIT_PERM of an out_len=300 run, then release and start with out_len=32 -> all outputs 0 during reset; the new run behaves exactly as scenario 1.
